// File: rtl/alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mc                                                       |
// | Description : Multi-cycle ALU with valid/ready handshakes. Logic, add/sub, |
// |               compare and shift ops finish in one cycle. Unsigned MUL and  |
// |               DIVU take WIDTH cycles, one bit per cycle (shift-add and     |
// |               restoring divide).                                           |
// | Config      : ALU_MC_MULDIV_EN - when defined, the iterative MUL/DIVU      |
// |               datapath is built. When undefined, opcodes 12/13 are        |
// |               illegal and no multiply/divide logic exists.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] c_OP_AND  = 4'd0;
  localparam logic [3:0] c_OP_OR   = 4'd1;
  localparam logic [3:0] c_OP_ADD  = 4'd2;
  localparam logic [3:0] c_OP_ANDN = 4'd4;
  localparam logic [3:0] c_OP_ORN  = 4'd5;
  localparam logic [3:0] c_OP_SUB  = 4'd6;
  localparam logic [3:0] c_OP_SLT  = 4'd7;
  localparam logic [3:0] c_OP_SLL  = 4'd8;
  localparam logic [3:0] c_OP_SRL  = 4'd9;
  localparam logic [3:0] c_OP_SRA  = 4'd10;
  localparam logic [3:0] c_OP_SLTU = 4'd11;
`ifdef ALU_MC_MULDIV_EN
  localparam logic [3:0] c_OP_MUL  = 4'd12;
  localparam logic [3:0] c_OP_DIVU = 4'd13;
  localparam logic [SHW-1:0] c_LAST_ITER = SHW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_y_hi;
  logic             r_zero;
  logic             r_err;

  logic [WIDTH-1:0] w_res;
  logic             w_illegal;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Single-cycle result for the opcode currently on the inputs
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (f)
      c_OP_AND:  w_res = a & b;
      c_OP_OR:   w_res = a | b;
      c_OP_ADD:  w_res = a + b;
      c_OP_ANDN: w_res = a & ~b;
      c_OP_ORN:  w_res = a | ~b;
      c_OP_SUB:  w_res = a - b;
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_SLL:  w_res = b << shamt;
      c_OP_SRL:  w_res = b >> shamt;
      c_OP_SRA:  w_res = $unsigned($signed(b) >>> shamt);
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:   w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  // Iteration registers shared by MUL and DIVU:
  //   MUL : r_hi = partial product high word, r_lo = multiplier shifting out
  //         while product low bits shift in, r_opnd = multiplicand.
  //   DIVU: r_hi = partial remainder, r_lo = dividend shifting out while
  //         quotient bits shift in, r_opnd = divisor.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_divz;
  logic [SHW-1:0]   r_cnt;

  logic             w_multi;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign w_multi = (f == c_OP_MUL) || (f == c_OP_DIVU);

  // One shift-add or restoring-divide step based on the current registers
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_hi    = w_mul_sum[WIDTH:1];
    w_mul_lo    = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    // Sign bit of the trial subtraction decides whether to restore
    if (!w_div_diff[WIDTH]) begin
      w_div_rem = w_div_diff[WIDTH-1:0];
      w_div_quo = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_div_rem = w_div_shift[WIDTH-1:0];
      w_div_quo = {r_lo[WIDTH-2:0], 1'b0};
    end
    w_step_hi = r_is_div ? w_div_rem : w_mul_hi;
    w_step_lo = r_is_div ? w_div_quo : w_mul_lo;
  end

  // Load operands on acceptance, then advance one bit per BUSY cycle.
  // A zero divisor needs no special path: every trial subtraction succeeds,
  // so the quotient fills with ones and the remainder rebuilds the dividend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_divz   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept && w_multi) begin
      r_hi     <= '0;
      r_lo     <= a;
      r_opnd   <= b;
      r_is_div <= (f == c_OP_DIVU);
      r_divz   <= (f == c_OP_DIVU) && (b == '0);
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_hi     <= w_step_hi;
      r_lo     <= w_step_lo;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_hi      <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            if (w_multi) begin
              r_state <= S_BUSY;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_y         <= w_res;
              r_y_hi      <= '0;
              r_zero      <= (w_res == '0);
              r_err       <= w_illegal;
            end
`else
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_y         <= w_res;
            r_y_hi      <= '0;
            r_zero      <= (w_res == '0);
            r_err       <= w_illegal;
`endif
          end
        end
        S_BUSY: begin
`ifdef ALU_MC_MULDIV_EN
          // The final step's result goes straight to the output registers
          if (r_cnt == c_LAST_ITER) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_y         <= w_step_lo;
            r_y_hi      <= w_step_hi;
            r_zero      <= (w_step_lo == '0);
            r_err       <= r_divz;
          end
`else
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_mc                                                    |
// | Description : Scoreboard bench for alu_mc. The driver pushes the expected  |
// |               result of each accepted op; a monitor pops and compares on   |
// |               each out_valid, also checking latency and hold stability.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_mc;

  localparam int W  = 32;
  localparam int SW = 5;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam logic [W-1:0] SIGN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, zero, err;
  logic [W-1:0]  a = '0, b = '0, y, y_hi;
  logic [3:0]    f = '0;
  logic [SW-1:0] shamt = '0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .f        (f),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .y_hi     (y_hi),
    .zero     (zero),
    .err      (err)
  );

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] yh;
    logic         err;
    logic         zero;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rmode = 0;     // 0 random out_ready, 1 held high, 2 held low
  int   last_acc = 0;
  bit   seen = 1'b0;
  logic [W-1:0] hy, hyh;
  logic         hz, he;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results from the opcode table using plain arithmetic
  function automatic exp_t model(input logic [3:0] fo, input logic [W-1:0] ao,
                                 input logic [W-1:0] bo, input logic [SW-1:0] so);
    exp_t e;
    logic [2*W-1:0] p;
    logic [W-1:0] ones;
    ones  = '1;
    e.y   = '0;
    e.yh  = '0;
    e.err = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (fo)
      4'd0:  e.y = ao & bo;
      4'd1:  e.y = ao | bo;
      4'd2:  e.y = ao + bo;
      4'd4:  e.y = ao & ~bo;
      4'd5:  e.y = ao | ~bo;
      4'd6:  e.y = ao - bo;
      4'd7:  e.y = ((ao ^ SIGN) < (bo ^ SIGN)) ? 1 : 0;
      4'd8:  e.y = bo << so;
      4'd9:  e.y = bo >> so;
      4'd10: e.y = (bo >> so) | (bo[W-1] ? ~(ones >> so) : '0);
      4'd11: e.y = (ao < bo) ? 1 : 0;
      4'd12: begin
        if (MD) begin
          p     = {{W{1'b0}}, ao} * {{W{1'b0}}, bo};
          e.y   = p[W-1:0];
          e.yh  = p[2*W-1:W];
          e.lat = W + 1;
        end else e.err = 1'b1;
      end
      4'd13: begin
        if (MD) begin
          e.lat = W + 1;
          if (bo == '0) begin
            e.y = ones; e.yh = ao; e.err = 1'b1;
          end else begin
            e.y = ao / bo; e.yh = ao % bo;
          end
        end else e.err = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: latency/value check on first out_valid, stability while held
  always @(negedge clk) begin
    if (reset_n) begin
      if (sb.size() != 0) chk("in_ready_low_while_busy", in_ready, 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got y=%0h expected no result", y);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            chk("y", y, sb[0].y);
            chk("y_hi", y_hi, sb[0].yh);
            chk("err", err, sb[0].err);
            chk("zero", zero, sb[0].zero);
            hy = y; hyh = y_hi; hz = zero; he = err;
          end else begin
            chk("hold_y", y, hy);
            chk("hold_y_hi", y_hi, hyh);
            chk("hold_flags", {zero, err}, {hz, he});
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] fo, input logic [W-1:0] ao,
                       input logic [W-1:0] bo, input logic [SW-1:0] so);
    exp_t e;
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    f = fo; a = ao; b = bo; shamt = so; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    e = model(fo, ao, bo, so);
    e.acc = cyc;
    sb.push_back(e);
    last_acc = cyc;
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; f = 4'($urandom); shamt = SW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_y_hi"}, y_hi, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Abort whatever is in flight, then accept on the first edge after release
  task automatic reset_pulse_and_first_accept(input string tag);
    exp_t e;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb.delete();
    seen = 1'b0;
    f = 4'd2; a = 32'd5; b = 32'd6; shamt = '0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rmode = 1;
    @(posedge clk);
    e = model(4'd2, 32'd5, 32'd6, '0);
    e.acc = cyc;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    chk({tag, "_first_accept"}, in_ready, 0);
    repeat (50) @(posedge clk);
  endtask

  initial begin
    int prev;
    logic [W-1:0] ra, rb;
    logic [3:0]   rf;

    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rmode = 1;

    // Directed single-cycle ops back to back, two cycles per op
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, '0);
    prev = last_acc;
    issue(4'd10, 32'h1234_5678, 32'h8000_0000, 5'd4);
    chk("throughput_sra", 64'(last_acc - prev), 2);
    prev = last_acc;
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, '0);
    chk("throughput_slt", 64'(last_acc - prev), 2);
    prev = last_acc;
    issue(4'd11, 32'hFFFF_FFFF, 32'd1, '0);
    chk("throughput_sltu", 64'(last_acc - prev), 2);
    issue(4'd8, 32'd0, 32'h0000_0001, 5'd31);
    issue(4'd9, 32'd0, 32'h8000_0000, 5'd31);
    issue(4'd6, 32'd0, 32'd1, '0);

    // Multi-cycle ops (illegal with latency 1 when MUL/DIVU is absent)
    issue(4'd12, 32'hFFFF_FFFF, 32'd2, '0);
    issue(4'd13, 32'd100, 32'd7, '0);
    issue(4'd13, 32'd100, 32'd0, '0);
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);

    // Illegal op held in DONE while a second op waits
    rmode = 2;
    issue(4'd3, 32'hDEAD_BEEF, 32'h1, '0);
    fork
      issue(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, '0);
      begin
        repeat (6) @(posedge clk);
        rmode = 1;
      end
    join
    issue(4'd15, 32'd0, 32'd0, '0);
    issue(4'd14, 32'd1, 32'd1, '0);

    // Reset during DONE
    rmode = 2;
    issue(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
    repeat (2) @(posedge clk);
    reset_pulse_and_first_accept("rst_done");

`ifdef ALU_MC_MULDIV_EN
    // Reset at cycle 10 of a MUL
    issue(4'd12, 32'hFFFF_FFFF, 32'd2, '0);
    repeat (9) @(posedge clk);
    reset_pulse_and_first_accept("rst_busy");
`endif

    // Randomized traffic
    rmode = 0;
    for (int i = 0; i < 300; i++) begin
      rf = 4'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = 32'($urandom_range(0, 1)) << 31;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = rb;
      issue(rf, ra, rb, SW'($urandom));
    end

    rmode = 1;
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 f  input  4  opcode.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  WIDTH  result (low word for MUL, quotient for DIVU).
REQ-014 y_hi  output  WIDTH  high product word for MUL, remainder for DIVU, zero otherwise.
REQ-015 zero  output  1  high when y == 0.
REQ-016 err  output  1  illegal opcode or divide-by-zero.

Function
REQ-017 Opcodes SHALL be: 0 a&b, 1 a|b, 2 a+b, 4 a&~b, 5 a|~b, 6 a-b, 7 signed a<b ?1:0, 8 b<<shamt, 9 b>>shamt logical, 10 b>>>shamt arithmetic, 11 unsigned a<b ?1:0, 12 MUL unsigned, 13 DIVU unsigned.
REQ-018 Opcodes 3, 14, 15 SHALL be illegal: y=0, y_hi=0, err=1; never drive Z or X.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-021 Accept = in_valid & in_ready at a rising edge; operands and opcode SHALL be captured then and input changes afterwards SHALL be ignored.
REQ-022 Single-cycle opcodes (0-11, illegal): IDLE->DONE at acceptance edge; out_valid SHALL be 1 in the next cycle (latency 1).
REQ-023 MUL/DIVU: IDLE->BUSY at acceptance; iterative shift-add / restoring divide, one bit per cycle; BUSY->DONE after exactly WIDTH cycles; out_valid high WIDTH+1 cycles after acceptance.
REQ-024 MUL SHALL produce the full 2*WIDTH-bit product {y_hi, y}.
REQ-025 DIVU with b==0 SHALL return y=all ones, y_hi=a, err=1, with the same WIDTH+1 latency.
REQ-026 DONE: y, y_hi, zero, err, out_valid SHALL be held stable until out_valid & out_ready; then DONE->IDLE.
REQ-027 in_valid during BUSY/DONE SHALL NOT be accepted; the producer holds it.
REQ-028 Back-to-back single-cycle throughput SHALL be one op per 2 cycles with out_ready held high.
REQ-029 zero and err SHALL be registered with y, valid only while out_valid=1.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, y=0, y_hi=0, zero=0, err=0, iteration counter=0.
REQ-031 Reset asserted during BUSY or DONE SHALL abort the operation; no result SHALL appear after release.
REQ-032 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-033 Macro ALU_MC_MULDIV_EN defined: MUL/DIVU implemented per REQ-023..025.
REQ-034 Macro undefined: opcodes 12, 13 SHALL behave as illegal (REQ-018, latency 1), BUSY never entered, no multiply/divide logic synthesised.

Verification
REQ-035 WIDTH=32, f=2, a=0xFFFFFFFF, b=1 -> out_valid next cycle, y=0, zero=1, err=0.
REQ-036 f=10, b=0x80000000, shamt=4 -> y=0xF8000000; f=7 a=0xFFFFFFFF b=1 -> y=1; f=11 same operands -> y=0.
REQ-037 With macro: f=12, a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept, y_hi=1, y=0xFFFFFFFE; in_ready=0 throughout.
REQ-038 With macro: f=13, a=100, b=7 -> y=14, y_hi=2; b=0 -> y=0xFFFFFFFF, y_hi=100, err=1.
REQ-039 f=3 -> y=0, err=1; out_ready held low 5 cycles -> outputs stable, in_valid ignored, then handshake returns to IDLE.
REQ-040 reset_n pulsed low at cycle 10 of a MUL -> outputs cleared asynchronously, in_ready=1, no out_valid after release.
